// File: rtl/magnitude_comparator.sv
// magnitude_comparator: registered greater/equal/less flags for two SIZE-bit operands
module magnitude_comparator #(
  parameter int SIZE   = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            in_valid,
  output logic            is_a_greater,
  output logic            equal,
  output logic            is_a_less,
  output logic            out_valid
);
  logic gt, eq, sign_diff;
  always_comb begin
    eq        = a == b;
    sign_diff = SIGNED && (a[SIZE-1] ^ b[SIZE-1]);
    // differing signs: a wins exactly when b is the negative one
    gt        = sign_diff ? b[SIZE-1] : a > b;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_a_greater <= 1'b0;
      equal        <= 1'b0;
      is_a_less    <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        is_a_greater <= gt;
        equal        <= eq;
        is_a_less    <= !gt && !eq;
      end
    end
  end
endmodule

// File: tb/tb_magnitude_comparator.sv
// tb_magnitude_comparator: randomized and directed checks of four comparator variants against an integer model
module tb_magnitude_comparator;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] o_u4, o_s4, o_u8, o_s8;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  magnitude_comparator #(.SIZE(4), .SIGNED(1'b0)) u_u4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(in_valid),
    .is_a_greater(o_u4[3]), .equal(o_u4[2]), .is_a_less(o_u4[1]), .out_valid(o_u4[0]));
  magnitude_comparator #(.SIZE(4), .SIGNED(1'b1)) u_s4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(in_valid),
    .is_a_greater(o_s4[3]), .equal(o_s4[2]), .is_a_less(o_s4[1]), .out_valid(o_s4[0]));
  magnitude_comparator #(.SIZE(8), .SIGNED(1'b0)) u_u8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
    .is_a_greater(o_u8[3]), .equal(o_u8[2]), .is_a_less(o_u8[1]), .out_valid(o_u8[0]));
  magnitude_comparator #(.SIZE(8), .SIGNED(1'b1)) u_s8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
    .is_a_greater(o_s8[3]), .equal(o_s8[2]), .is_a_less(o_s8[1]), .out_valid(o_s8[0]));

  // {gt, eq, lt} from plain integer values of the operands
  function automatic logic [2:0] model(int a, int b, int w, bit s);
    int va, vb;
    va = (s && a >= (1 << (w - 1))) ? a - (1 << w) : a;
    vb = (s && b >= (1 << (w - 1))) ? b - (1 << w) : b;
    return {va > vb, va == vb, va < vb};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; a4 = 4'hF; b4 = 4'h0; a8 = 8'hFF; b8 = 8'h00;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({o_u4, o_s4, o_u8, o_s8} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h required 0000", {o_u4, o_s4, o_u8, o_s8});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({o_u4, o_s4, o_u8, o_s8} !== {4'b1001, 4'b0011, 4'b1001, 4'b0011}) begin
      n_fail++;
      $display("FAIL reset_release: got %h required 9393", {o_u4, o_s4, o_u8, o_s8});
    end
  endtask

  task automatic test_directed;
    logic [3:0] pa [7] = '{4'h0, 4'h1, 4'h0, 4'hF, 4'hF, 4'h7, 4'h8};
    logic [3:0] pb [7] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'h8, 4'h8};
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (o_u4 !== {model(pa[i-1], pb[i-1], 4, 1'b0), 1'b1}) begin
          n_fail++;
          $display("FAIL directed_u4 a=%h b=%h: got %b required %b1", pa[i-1], pb[i-1], o_u4, model(pa[i-1], pb[i-1], 4, 1'b0));
        end
        n_cmp++;
        if (o_s4 !== {model(pa[i-1], pb[i-1], 4, 1'b1), 1'b1}) begin
          n_fail++;
          $display("FAIL directed_s4 a=%h b=%h: got %b required %b1", pa[i-1], pb[i-1], o_s4, model(pa[i-1], pb[i-1], 4, 1'b1));
        end
      end
      if (i < 7) begin
        in_valid = 1'b1; a4 = pa[i]; b4 = pb[i];
      end
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    in_valid = 1'b1; a4 = 4'h1; b4 = 4'h0; a8 = 8'h05; b8 = 8'h03;
    @(negedge clk);
    in_valid = 1'b0; a4 = 4'h0; b4 = 4'hF; a8 = 'x; b8 = 'z;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({o_u4, o_s4, o_u8, o_s8} !== 16'h8888) begin
        n_fail++;
        $display("FAIL hold: got %h required 8888", {o_u4, o_s4, o_u8, o_s8});
      end
    end
    a8 = '0; b8 = '0;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    in_valid = 1'b1; a4 = 4'h3; b4 = 4'h9; a8 = 8'h80; b8 = 8'h7F;
    @(negedge clk);
    n_cmp++;
    if (o_s8 !== 4'b0011) begin
      n_fail++;
      $display("FAIL pre_reset_s8: got %b required 0011", o_s8);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_u4, o_s4, o_u8, o_s8} !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 0000", {o_u4, o_s4, o_u8, o_s8});
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_random;
    logic [2:0] e_u4 = '0, e_s4 = '0, e_u8 = '0, e_s8 = '0;
    logic e_v = 1'b0;
    for (int k = 0; k <= 3000; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_cmp++;
        if ({o_u4, o_s4, o_u8, o_s8} !== {e_u4, e_v, e_s4, e_v, e_u8, e_v, e_s8, e_v}) begin
          n_fail++;
          $display("FAIL random k=%0d: got %h required %h", k,
            {o_u4, o_s4, o_u8, o_s8}, {e_u4, e_v, e_s4, e_v, e_u8, e_v, e_s8, e_v});
        end
        if (e_v) begin
          n_cmp++;
          if ($countones(o_u8[3:1]) != 1 || $countones(o_s8[3:1]) != 1) begin
            n_fail++;
            $display("FAIL onehot k=%0d: got u8=%b s8=%b required one flag each", k, o_u8[3:1], o_s8[3:1]);
          end
        end
      end
      in_valid = $urandom_range(3) != 0;
      a4 = 4'($urandom); b4 = ($urandom_range(7) == 0) ? a4 : 4'($urandom);
      a8 = 8'($urandom); b8 = ($urandom_range(7) == 0) ? a8 : 8'($urandom);
      e_v = in_valid;
      if (in_valid) begin
        e_u4 = model(a4, b4, 4, 1'b0); e_s4 = model(a4, b4, 4, 1'b1);
        e_u8 = model(a8, b8, 8, 1'b0); e_s8 = model(a8, b8, 8, 1'b1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/magnitude_comparator.md
Name: magnitude_comparator

Overview:
- Registered magnitude comparator for two SIZE-bit operands, used in the 8-bit ALU datapath to produce greater-than and equality flags.
- Operands are compared combinationally and the flags are captured on the next rising clock edge, giving a one-cycle latency.
- A less-than flag is also provided, so downstream condition logic needs no extra gates.

Parameters:
- SIZE, 4, operand width in bits (≥1).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement signed compare.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  SIZE  operand A.
- b  input  SIZE  operand B.
- in_valid  input  1  qualifies a/b for this cycle.
- is_a_greater  output  1  registered: A > B.
- equal  output  1  registered: A == B.
- is_a_less  output  1  registered: A < B.
- out_valid  output  1  registered copy of in_valid; flags are meaningful when high.

Behaviour:
- Reset:
  - rst_n low asynchronously clears is_a_greater, equal, is_a_less and out_valid to 0, independent of clk.
  - Outputs stay 0 while rst_n is low.
  - Release is synchronous in effect: the first capture happens on the first rising clk edge with rst_n high.
- Latency: on each rising clk edge with rst_n high and in_valid high, the flags for the current a/b are registered. out_valid <= 1 on that same edge.
- in_valid low at a rising edge: out_valid <= 0 and the flags hold their previous values (no update).
- Comparison, SIGNED=0: a and b are treated as unsigned.
- Comparison, SIGNED=1: the MSB is the sign bit. A negative operand is less than any non-negative operand. Otherwise the lower bits are compared unsigned.
- Exclusivity: exactly one of is_a_greater, equal, is_a_less is 1 whenever out_valid is 1.
- Equality is bitwise identity of a and b and does not depend on SIGNED.
- Back-to-back: a new operand pair may be presented every cycle (throughput 1/cycle). No backpressure.
- Reset mid-stream: any pending result is discarded and out_valid drops immediately.
- X/Z on a/b while in_valid is low must not propagate to the flags.

Test Plan:
- Reset: hold rst_n low, toggle clk with a=4'hF, b=4'h0, in_valid=1. Expect all outputs 0. Deassert rst_n; one edge later expect is_a_greater=1, equal=0, is_a_less=0, out_valid=1.
- Unsigned directed (SIZE=4, SIGNED=0), one pair per cycle with in_valid=1; check one cycle later:
  - a=0, b=0 -> is_a_greater=0, equal=1.
  - a=1, b=0 -> is_a_greater=1, equal=0.
  - a=0, b=1 -> is_a_greater=0, equal=0, is_a_less=1.
  - a=F, b=0 -> is_a_greater=1, equal=0.
  - a=F, b=F -> is_a_greater=0, equal=1.
- Signed (SIGNED=1, SIZE=4):
  - a=4'hF (−1), b=4'h0 -> is_a_less=1.
  - a=4'h7, b=4'h8 -> is_a_greater=1.
  - a=4'h8, b=4'h8 -> equal=1.
- Hold: after a=1, b=0 is captured, drop in_valid and drive a=0, b=F. Expect out_valid=0 and is_a_greater still 1.
- Async reset mid-stream: assert rst_n low between clock edges. Expect all outputs 0 immediately, without waiting for a clock edge.
- Exhaustive/random at SIZE=8, both SIGNED settings, compared against a reference model with one-cycle delay. Expect exactly one flag high on every out_valid cycle.
